sample_fetch_ctrl: RTL and testbench
====================================

SAMPLE_FETCH_CTRL -- requirements
Module: sample_fetch_ctrl

Interface
REQ-001 SHALL have parameter ROM_BASE, default 24'h000000, meaning the byte offset of the sample ROM in external memory.
REQ-002 SHALL have parameter ROM_AW, default 24, meaning the external address width.
REQ-003 SHALL have port CLK_32M, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port sample_addr, input, 16 bits: address byte(s) from the sound block.
REQ-006 SHALL have port sample_addr_wr, input, 2 bits: bit0 loads addr[7:0] from sample_addr[7:0]; bit1 loads addr[15:8] from sample_addr[15:8]; 1-cycle strobes.
REQ-007 SHALL have port sample_inc, input, 1 bit: 1-cycle strobe that advances the address by one.
REQ-008 SHALL have port pause, input, 1 bit: freezes new request issue.
REQ-009 SHALL have port rom_addr, output, ROM_AW bits: ROM_BASE + current fetch address, zero-extended.
REQ-010 SHALL have port rom_req, output, 1 bit: level request, held until acknowledged.
REQ-011 SHALL have port rom_ack, input, 1 bit: 1-cycle data-valid strobe for the outstanding request.
REQ-012 SHALL have port rom_data, input, 8 bits: ROM byte, valid when rom_ack=1.
REQ-013 SHALL have port sample_in, output, 8 bits: byte at the current address, returned to the Z80.
REQ-014 SHALL have port sample_valid, output, 1 bit: sample_in corresponds to the current address.
REQ-015 SHALL have port cur_addr, output, 16 bits: current sample address register.

Function
REQ-016 SHALL hold a 16-bit address register; a byte load writes only its selected byte; both bits set load both bytes in the same cycle.
REQ-017 SHALL advance the address on sample_inc with modulo-2^16 wrap (FFFF->0000).
REQ-018 SHALL implement FSM states IDLE, FETCH_CUR, FETCH_NEXT.
- IDLE->FETCH_CUR when sample_valid=0 and pause=0.
- FETCH_CUR->IDLE on rom_ack, or ->FETCH_NEXT when prefetch is enabled.
- FETCH_NEXT->IDLE on rom_ack.
REQ-019 SHALL drive rom_req=1 throughout FETCH_CUR/FETCH_NEXT and drop it in the cycle after rom_ack; rom_addr SHALL be stable while rom_req=1.
REQ-020 SHALL, on rom_ack in FETCH_CUR, register rom_data into sample_in and set sample_valid the next cycle (latency: ack -> valid = 1 cycle).
REQ-021 SHALL, on an address load or sample_inc, clear sample_valid in the next cycle.
REQ-022 SHALL, on an address load or sample_inc while a request is outstanding, keep rom_req asserted until rom_ack, mark the reply stale, and discard it; a fetch of the new address SHALL follow.
REQ-023 SHALL give an address load priority over a same-cycle sample_inc; the inc is dropped.
REQ-024 SHALL ignore rom_ack when no request is outstanding.
REQ-025 SHALL issue no new request while pause=1; an outstanding request SHALL complete normally.

Reset
REQ-026 SHALL, while reset_n=0, set the address to 0000, sample_in to 8'h00, sample_valid=0, rom_req=0, and state=IDLE, and clear the stale and prefetch flags.
REQ-027 SHALL abandon any in-flight request on reset; an ack arriving after reset release with no request outstanding is ignored (REQ-024).

Configuration
REQ-028 SHALL, with macro SAMPLE_PREFETCH_EN defined, keep a 1-byte next buffer for address+1 (with wrap), filled in FETCH_NEXT.
- With SAMPLE_PREFETCH_EN defined: a sample_inc with the buffer valid moves the buffer to sample_in, and sample_valid stays 1 with no gap.
- Without it: FETCH_NEXT is unreachable and every inc triggers a FETCH_CUR.

Verification
REQ-029 Bench SHALL cover: addr_wr=2'b11, sample_addr=16'h1234, ROM_BASE=24'h080000 -> rom_addr=24'h081234, rom_req held; ack with data 8'hA5 -> sample_in=8'hA5 and sample_valid=1 one cycle later.
REQ-030 Bench SHALL cover: address FFFF plus sample_inc -> cur_addr=0000, and the next fetch rom_addr=ROM_BASE.
REQ-031 Bench SHALL cover: load 16'h0010, then sample_inc during FETCH_CUR -> first ack discarded, second request at ROM_BASE+0x11, sample_in equals the second ack's data.
REQ-032 Bench SHALL cover: same-cycle addr_wr=2'b01 with sample_addr[7:0]=8'h40 and sample_inc, from address 0x1200 -> cur_addr=16'h1240.
REQ-033 Bench SHALL cover: with SAMPLE_PREFETCH_EN, after both fetches complete, sample_inc -> sample_valid never drops and sample_in equals the prefetched byte the next cycle.
REQ-034 Bench SHALL cover: reset_n=0 mid-request, then a stray rom_ack -> outputs at reset values and no state change.

Source files
------------

// File: rtl/sample_fetch_ctrl.sv
// Sample ROM fetch controller: tracks the Z80 sample address and fetches the byte at it from external ROM.
// Optional next-byte prefetch buffer enabled by defining SAMPLE_PREFETCH_EN.
module sample_fetch_ctrl #(
    parameter logic [23:0] ROM_BASE = 24'h000000,
    parameter int unsigned ROM_AW   = 24
) (
    input  logic              CLK_32M,
    input  logic              reset_n,
    input  logic [15:0]       sample_addr,
    input  logic [1:0]        sample_addr_wr,
    input  logic              sample_inc,
    input  logic              pause,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_req,
    input  logic              rom_ack,
    input  logic [7:0]        rom_data,
    output logic [7:0]        sample_in,
    output logic              sample_valid,
    output logic [15:0]       cur_addr
);

`ifdef SAMPLE_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH_CUR  = 2'd1,
        FETCH_NEXT = 2'd2
    } state_t;

    state_t      state;
    logic        stale;
    logic [7:0]  next_buf;
    logic        next_valid;

    logic [15:0] ld_val;
    logic [15:0] nxt_addr;
    logic        addr_ld;
    logic        addr_chg;
    logic        take_next;

    function automatic logic [ROM_AW-1:0] to_rom(input logic [15:0] a);
        return ROM_AW'(ROM_BASE) + ROM_AW'(a);
    endfunction

    // Byte-lane merge of the address load; a load wins over a same-cycle increment.
    always_comb begin
        ld_val = cur_addr;
        if (sample_addr_wr[0]) ld_val[7:0]  = sample_addr[7:0];
        if (sample_addr_wr[1]) ld_val[15:8] = sample_addr[15:8];
    end

    assign addr_ld   = |sample_addr_wr;
    assign addr_chg  = addr_ld | sample_inc;
    assign nxt_addr  = addr_ld ? ld_val : cur_addr + 16'd1;
    assign take_next = PREFETCH && sample_inc && !addr_ld && next_valid && sample_valid;

    always_ff @(posedge CLK_32M) begin
        if (!reset_n) begin
            state        <= IDLE;
            cur_addr     <= 16'h0000;
            sample_in    <= 8'h00;
            sample_valid <= 1'b0;
            rom_req      <= 1'b0;
            rom_addr     <= to_rom(16'h0000);
            stale        <= 1'b0;
            next_buf     <= 8'h00;
            next_valid   <= 1'b0;
        end else begin
            // Any address change invalidates the current byte unless the prefetched byte covers it.
            if (addr_chg) begin
                cur_addr   <= nxt_addr;
                next_valid <= 1'b0;
                if (take_next) begin
                    sample_in <= next_buf;
                end else begin
                    sample_valid <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (!sample_valid && !pause) begin
                        state    <= FETCH_CUR;
                        rom_req  <= 1'b1;
                        rom_addr <= to_rom(addr_chg ? nxt_addr : cur_addr);
                    end
                end

                FETCH_CUR: begin
                    if (rom_ack) begin
                        stale <= 1'b0;
                        if (stale || addr_chg) begin
                            state   <= IDLE;
                            rom_req <= 1'b0;
                        end else begin
                            sample_in    <= rom_data;
                            sample_valid <= 1'b1;
                            if (PREFETCH && !pause) begin
                                state    <= FETCH_NEXT;
                                rom_addr <= to_rom(cur_addr + 16'd1);
                            end else begin
                                state   <= IDLE;
                                rom_req <= 1'b0;
                            end
                        end
                    end else if (addr_chg) begin
                        stale <= 1'b1;
                    end
                end

                FETCH_NEXT: begin
                    if (rom_ack) begin
                        if (!stale && !addr_chg) begin
                            next_buf   <= rom_data;
                            next_valid <= 1'b1;
                        end
                        stale   <= 1'b0;
                        state   <= IDLE;
                        rom_req <= 1'b0;
                    end else if (addr_chg) begin
                        stale <= 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    rom_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_fetch_ctrl.sv
// Bench for sample_fetch_ctrl: directed scenarios then randomized traffic against a ROM-content reference model.
module tb_sample_fetch_ctrl;

    localparam logic [23:0] BASE = 24'h080000;

    logic        CLK_32M;
    logic        reset_n;
    logic [15:0] sample_addr;
    logic [1:0]  sample_addr_wr;
    logic        sample_inc;
    logic        pause;
    logic [23:0] rom_addr;
    logic        rom_req;
    logic        rom_ack;
    logic [7:0]  rom_data;
    logic [7:0]  sample_in;
    logic        sample_valid;
    logic [15:0] cur_addr;

    int errors = 0;
    int checks = 0;

    sample_fetch_ctrl #(.ROM_BASE(BASE), .ROM_AW(24)) dut (
        .CLK_32M        (CLK_32M),
        .reset_n        (reset_n),
        .sample_addr    (sample_addr),
        .sample_addr_wr (sample_addr_wr),
        .sample_inc     (sample_inc),
        .pause          (pause),
        .rom_addr       (rom_addr),
        .rom_req        (rom_req),
        .rom_ack        (rom_ack),
        .rom_data       (rom_data),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .cur_addr       (cur_addr)
    );

    initial begin
        CLK_32M = 1'b0;
        forever #5 CLK_32M = ~CLK_32M;
    end

    // Reference ROM contents, indexed by offset from BASE.
    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0] * 8'd7;
        return lo ^ a[15:8] ^ 8'hC3;
    endfunction

    task automatic tick();
        @(posedge CLK_32M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_ack(input logic [7:0] d);
        rom_ack  = 1'b1;
        rom_data = d;
        tick();
        rom_ack  = 1'b0;
    endtask

    // In prefetch builds the next-byte fetch follows the current one; serve it so the next scenario starts idle.
    task automatic finish_prefetch(input logic [7:0] d);
`ifdef SAMPLE_PREFETCH_EN
        check("pf_req", 32'(rom_req), 32'h1);
        check("pf_addr", 32'(rom_addr), 32'(BASE + 24'(cur_addr + 16'd1)));
        do_ack(d);
        check("pf_req_drop", 32'(rom_req), 32'h0);
`else
        check("no_pf_req", 32'(rom_req), 32'h0);
        rom_data = d;
`endif
    endtask

    task automatic load(input logic [15:0] a);
        sample_addr    = a;
        sample_addr_wr = 2'b11;
        tick();
        sample_addr_wr = 2'b00;
    endtask

    logic [15:0] model_addr;
    logic [15:0] merged;
    logic [23:0] prev_addr;
    logic        prev_req;
    logic        ack_drv;
    logic        chg_drv;
    logic        ld_drv;
    int unsigned lat;
    int unsigned r;
    int unsigned starve;

    initial begin
        reset_n        = 1'b0;
        pause          = 1'b1;
        sample_addr    = 16'h0000;
        sample_addr_wr = 2'b00;
        sample_inc     = 1'b0;
        rom_ack        = 1'b0;
        rom_data       = 8'h00;
        repeat (3) tick();

        check("rst_cur_addr", 32'(cur_addr), 32'h0);
        check("rst_sample_in", 32'(sample_in), 32'h0);
        check("rst_valid", 32'(sample_valid), 32'h0);
        check("rst_req", 32'(rom_req), 32'h0);
        check("rst_rom_addr", 32'(rom_addr), 32'(BASE));
        reset_n = 1'b1;
        tick();

        // Full load and basic fetch
        load(16'h1234);
        check("t1_cur_addr", 32'(cur_addr), 32'h1234);
        check("t1_paused_req", 32'(rom_req), 32'h0);
        pause = 1'b0;
        tick();
        check("t1_req", 32'(rom_req), 32'h1);
        check("t1_rom_addr", 32'(rom_addr), 32'h081234);
        tick();
        tick();
        check("t1_req_held", 32'(rom_req), 32'h1);
        check("t1_addr_held", 32'(rom_addr), 32'h081234);
        check("t1_valid_pre", 32'(sample_valid), 32'h0);
        do_ack(8'hA5);
        check("t1_sample_in", 32'(sample_in), 32'hA5);
        check("t1_valid", 32'(sample_valid), 32'h1);
        finish_prefetch(8'h5E);

        // Wrap FFFF -> 0000
        pause = 1'b1;
        load(16'hFFFF);
        check("t2_cur_ffff", 32'(cur_addr), 32'hFFFF);
        check("t2_valid_clr", 32'(sample_valid), 32'h0);
        sample_inc = 1'b1;
        tick();
        sample_inc = 1'b0;
        check("t2_wrap", 32'(cur_addr), 32'h0);
        pause = 1'b0;
        tick();
        check("t2_req", 32'(rom_req), 32'h1);
        check("t2_rom_addr", 32'(rom_addr), 32'(BASE));
        do_ack(8'h9B);
        check("t2_sample_in", 32'(sample_in), 32'h9B);
        check("t2_valid", 32'(sample_valid), 32'h1);
        finish_prefetch(8'h11);

        // Increment during an outstanding fetch: stale reply discarded, refetch follows
        pause = 1'b1;
        load(16'h0010);
        pause = 1'b0;
        tick();
        check("t3_rom_addr1", 32'(rom_addr), 32'h080010);
        sample_inc = 1'b1;
        tick();
        sample_inc = 1'b0;
        check("t3_cur_addr", 32'(cur_addr), 32'h0011);
        check("t3_req_held", 32'(rom_req), 32'h1);
        check("t3_addr_held", 32'(rom_addr), 32'h080010);
        do_ack(8'h77);
        check("t3_stale_valid", 32'(sample_valid), 32'h0);
        check("t3_req_drop", 32'(rom_req), 32'h0);
        tick();
        check("t3_req2", 32'(rom_req), 32'h1);
        check("t3_rom_addr2", 32'(rom_addr), 32'h080011);
        do_ack(8'h3C);
        check("t3_sample_in", 32'(sample_in), 32'h3C);
        check("t3_valid", 32'(sample_valid), 32'h1);
        finish_prefetch(8'h4D);

        // Low-byte load beats same-cycle increment
        pause = 1'b1;
        load(16'h1200);
        sample_addr    = 16'hAB40;
        sample_addr_wr = 2'b01;
        sample_inc     = 1'b1;
        tick();
        sample_addr_wr = 2'b00;
        sample_inc     = 1'b0;
        check("t4_cur_addr", 32'(cur_addr), 32'h1240);
        tick();
        check("t4_cur_stable", 32'(cur_addr), 32'h1240);

        // Increment after the fetch(es) complete
        load(16'h0200);
        pause = 1'b0;
        tick();
        check("t5_rom_addr", 32'(rom_addr), 32'h080200);
        do_ack(8'h11);
        check("t5_sample_in", 32'(sample_in), 32'h11);
        check("t5_valid", 32'(sample_valid), 32'h1);
`ifdef SAMPLE_PREFETCH_EN
        check("t5_pf_req", 32'(rom_req), 32'h1);
        check("t5_pf_addr", 32'(rom_addr), 32'h080201);
        do_ack(8'h22);
        check("t5_pf_done", 32'(rom_req), 32'h0);
        check("t5_valid_hold", 32'(sample_valid), 32'h1);
        sample_inc = 1'b1;
        tick();
        sample_inc = 1'b0;
        check("t5_inc_valid", 32'(sample_valid), 32'h1);
        check("t5_inc_data", 32'(sample_in), 32'h22);
        check("t5_inc_addr", 32'(cur_addr), 32'h0201);
        tick();
        check("t5_valid_after", 32'(sample_valid), 32'h1);
        check("t5_no_req", 32'(rom_req), 32'h0);
`else
        sample_inc = 1'b1;
        tick();
        sample_inc = 1'b0;
        check("t5_inc_valid", 32'(sample_valid), 32'h0);
        check("t5_inc_addr", 32'(cur_addr), 32'h0201);
        tick();
        check("t5_req2", 32'(rom_req), 32'h1);
        check("t5_rom_addr2", 32'(rom_addr), 32'h080201);
        do_ack(8'h22);
        check("t5_inc_data", 32'(sample_in), 32'h22);
        check("t5_valid2", 32'(sample_valid), 32'h1);
`endif

        // Reset mid-request, then a stray ack after release
        pause = 1'b1;
        load(16'h0300);
        pause = 1'b0;
        tick();
        check("t6_req", 32'(rom_req), 32'h1);
        check("t6_rom_addr", 32'(rom_addr), 32'h080300);
        reset_n = 1'b0;
        pause   = 1'b1;
        tick();
        check("t6_rst_cur", 32'(cur_addr), 32'h0);
        check("t6_rst_in", 32'(sample_in), 32'h0);
        check("t6_rst_valid", 32'(sample_valid), 32'h0);
        check("t6_rst_req", 32'(rom_req), 32'h0);
        check("t6_rst_rom_addr", 32'(rom_addr), 32'(BASE));
        tick();
        reset_n = 1'b1;
        tick();
        do_ack(8'hFF);
        check("t6_stray_in", 32'(sample_in), 32'h0);
        check("t6_stray_valid", 32'(sample_valid), 32'h0);
        check("t6_stray_req", 32'(rom_req), 32'h0);
        check("t6_stray_cur", 32'(cur_addr), 32'h0);
        tick();
        check("t6_idle_req", 32'(rom_req), 32'h0);

        // Randomized traffic against the address/ROM model
        pause      = 1'b0;
        model_addr = 16'h0000;
        lat        = 0;
        starve     = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sample_addr_wr = 2'b00;
            sample_inc     = 1'b0;
            rom_ack        = 1'b0;
            r = $urandom_range(0, 99);
            if (r < 6) begin
                sample_addr    = 16'($urandom);
                sample_addr_wr = 2'($urandom_range(1, 3));
            end
            if (r >= 4 && r < 14) sample_inc = 1'b1;
            if ($urandom_range(0, 49) == 0) pause = ~pause;
            if (rom_req) begin
                if (lat == 0) begin
                    rom_ack  = 1'b1;
                    rom_data = rom_byte(16'(rom_addr - BASE));
                    lat      = $urandom_range(0, 4);
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 29) == 0) begin
                rom_ack  = 1'b1;
                rom_data = 8'($urandom);
            end

            ld_drv  = |sample_addr_wr;
            chg_drv = ld_drv | sample_inc;
            ack_drv = rom_ack;
            merged  = model_addr;
            if (sample_addr_wr[0]) merged[7:0]  = sample_addr[7:0];
            if (sample_addr_wr[1]) merged[15:8] = sample_addr[15:8];
            if (ld_drv) model_addr = merged;
            else if (sample_inc) model_addr = model_addr + 16'd1;
            prev_req  = rom_req;
            prev_addr = rom_addr;

            tick();

            check("rnd_cur_addr", 32'(cur_addr), 32'(model_addr));
            if (sample_valid) check("rnd_sample_in", 32'(sample_in), 32'(rom_byte(cur_addr)));
            if (prev_req && !ack_drv) check("rnd_req_stable", 32'({rom_req, rom_addr}), 32'({1'b1, prev_addr}));
`ifdef SAMPLE_PREFETCH_EN
            if (ld_drv) check("rnd_valid_clr", 32'(sample_valid), 32'h0);
`else
            if (chg_drv) check("rnd_valid_clr", 32'(sample_valid), 32'h0);
`endif
            if (pause || sample_valid || chg_drv) starve = 0;
            else starve++;
            check("rnd_liveness", 32'(starve < 40), 32'h1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
